fejkon_pcie_cpl_tx: RTL and testbench
=====================================

// Module: fejkon_pcie_cpl_tx
// PURPOSE
//  Completion encoder for the PCIe endpoint data path: consumes memory-access responses (Avalon-ST, 128-bit)
//  and emits single-beat CplD/Cpl TLPs on the 256-bit hard-IP TX Avalon-ST interface.
//  Obeys the hard IP's TX ready latency.
//  Sits between the MMIO access engine (response side) and the hard IP tx_st port.
// PARAMETERS
//  FIFO_DEPTH     4  response buffer entries; power of 2, >=2
//  READY_LATENCY  3  cycles from tx_st_ready high to permitted tx_st_valid; range 1..4
// PORTS
//  clk                    in   1    clock
//  reset                  in   1    asynchronous, active-high reset
//  cpl_completer_id       in   16   {bus[7:0],dev[4:0],fn[2:0]}; sampled per TLP at FIFO pop
//  mem_access_resp_data   in   128  response word, layout below
//  mem_access_resp_valid  in   1    response valid
//  mem_access_resp_ready  out  1    response ready (readyLatency 0)
//  tx_st_data             out  256  TLP dwords, dword i = bits [32i+31:32i]
//  tx_st_startofpacket    out  1    always equals tx_st_valid
//  tx_st_endofpacket      out  1    always equals tx_st_valid
//  tx_st_empty            out  2    empty 64-bit units; 2 when valid, else 0
//  tx_st_error            out  1    tied 0
//  tx_st_valid            out  1    TLP beat valid
//  tx_st_ready            in   1    hard IP ready (READY_LATENCY semantics)
// BEHAVIOUR
//  Response word:
//   [127:96] data
//   [95:80]  requester_id
//   [79:72]  tag
//   [71:69]  status (000 SC, 001 UR, 100 CA)
//   [68:62]  lower_addr
//   [61:50]  byte_count
//   [49:0]   reserved, ignored
//  Encoding, status==SC (CplD):
//   dw0 = fmt 2'b10 @[30:29], type 5'b01010 @[28:24], length 1 @[9:0], all else 0
//  Encoding, status!=SC (Cpl):
//   dw0 fmt 2'b00, length 0; dw3 = 0
//  Common dwords:
//   dw1 = {completer_id, status, 1'b0 BCM, byte_count}
//   dw2 = {requester_id, tag, 1'b0, lower_addr}
//   dw3 = data (SC only); dw4..dw7 = 0
//  Status values outside {000,001,100} are encoded as CA (100).
//  Reset (async) values:
//   all outputs 0; FIFO emptied; ready-delay line cleared
//   mem_access_resp_ready stays 0 until the first clk edge after reset deasserts
//  Input handshake:
//   mem_access_resp_ready is registered: 1 iff FIFO will have a free slot next cycle
//   beat accepted when valid & ready; no accept when FIFO full; simultaneous push+pop when full is allowed
//  Ready tracking:
//   rdy_dly = tx_st_ready delayed READY_LATENCY-1 registers
//   a beat may be registered out at edge E only if rdy_dly is high at E
//   so tx_st_valid in cycle t implies tx_st_ready was high in cycle t-READY_LATENCY
//  Output stage:
//   registered; tx_st_valid held 1 cycle per TLP, one TLP per permitted cycle, strict FIFO order
//   tx_st_data is 0 whenever valid=0
//  Latency: beat accepted at edge N -> tx_st_valid earliest in cycle after edge N+1 (2 cycles), given permission.
//  FIFO empty while permitted: valid=0, permission is not banked. Pointers wrap modulo FIFO_DEPTH.
//  Reset mid-operation: queued and in-flight TLPs discarded, valid drops asynchronously, nothing replayed.
// CONFIGURATION
//  FEJKON_PCIE_CPL_TX_STATS_EN defined:
//   adds outputs stat_cpld_cnt[31:0], stat_cpl_cnt[31:0], stat_stall_cnt[31:0]
//   counters increment on emitted CplD, emitted Cpl, and cycles with FIFO non-empty but no permission
//   counters saturate at 2^32-1 and reset to 0
//  Not defined: the stat_* ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  fejkon_pcie_pkg holds:
//   TLP fmt/type constants
//   cpl_status_t enum
//   mem_access_resp_t packed struct with the response layout above
//  Sub-module fejkon_sync_fifo (DEPTH, WIDTH=128; full/empty/push/pop) implements the response buffer.
// TESTING
//  1. id=0x0300; SC resp req 0x0100, tag 0x2A, la 0x10, bc 4, data 0xDEADBEEF; ready=1
//     -> dw0..3 = 4A000001 03000004 01002A10 DEADBEEF; sop=eop=1; empty=2
//  2. Same fields, status UR -> dw0 0A000000, dw1 03002004, dw2 01002A10, dw3 00000000
//  3. ready=0 for 20 cycles, 6 responses offered
//     -> exactly 4 accepted, resp_ready=0, no tx_st_valid
//     -> after ready=1: 6 TLPs in order, first valid exactly READY_LATENCY+1 cycles after ready rises
//  4. ready toggling 1,0,1,0 with 4 queued -> each valid pulse lands exactly READY_LATENCY cycles after a ready-high cycle
//  5. Reset asserted with 3 queued, mid-burst -> valid=0 same cycle; after release no TLP emitted; resp_ready=1 one edge later
//  6. STATS_EN: 3 SC + 2 CA with 5 stall cycles -> cpld=3, cpl=2, stall=5; undefined build compiles without stat ports

Source files
------------

// File: rtl/fejkon_pcie_pkg.sv
// Shared types and helpers for the fejkon PCIe completion path:
// TLP fmt/type constants, completion status enum, the memory-access
// response word layout and the single-beat completion encoder.
package fejkon_pcie_pkg;

   localparam logic [1:0] TLP_FMT_3DW_NODATA = 2'b00;
   localparam logic [1:0] TLP_FMT_3DW_DATA   = 2'b10;
   localparam logic [4:0] TLP_TYPE_CPL       = 5'b01010;

   typedef enum logic [2:0] {
      CPL_SC = 3'b000,
      CPL_UR = 3'b001,
      CPL_CA = 3'b100
   } cpl_status_t;

   // Response word as produced by the MMIO access engine (128 bits).
   typedef struct packed {
      logic [31:0] data;
      logic [15:0] requester_id;
      logic [7:0]  tag;
      logic [2:0]  status;
      logic [6:0]  lower_addr;
      logic [11:0] byte_count;
      logic [49:0] rsvd;
   } mem_access_resp_t;

   // Anything that is not a recognised status is reported as Completer Abort.
   function automatic cpl_status_t norm_status(input logic [2:0] s);
      case (s)
         3'b000:  return CPL_SC;
         3'b001:  return CPL_UR;
         default: return CPL_CA;
      endcase
   endfunction

   // Build the 8-dword beat; only SC carries a payload dword (CplD).
   function automatic logic [255:0] encode_cpl(input mem_access_resp_t r,
                                               input logic [15:0] cid);
      cpl_status_t st;
      logic        is_d;
      logic [31:0] dw0, dw1, dw2, dw3;
      st          = norm_status(r.status);
      is_d        = (st == CPL_SC);
      dw0         = '0;
      dw0[30:29]  = is_d ? TLP_FMT_3DW_DATA : TLP_FMT_3DW_NODATA;
      dw0[28:24]  = TLP_TYPE_CPL;
      dw0[9:0]    = is_d ? 10'd1 : 10'd0;
      dw1         = {cid, st, 1'b0, r.byte_count};
      dw2         = {r.requester_id, r.tag, 1'b0, r.lower_addr};
      dw3         = is_d ? r.data : 32'h0;
      return {128'h0, dw3, dw2, dw1, dw0};
   endfunction

endpackage

// File: rtl/fejkon_sync_fifo.sv
// Single-clock FIFO with head-of-queue read (show-ahead).
// Push while full is honoured only together with a pop. o_free_next
// tells the producer whether a slot will be free after this edge.
module fejkon_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_free_next
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr, r_rd;
   logic [AW:0]      r_cnt, w_cnt_nxt;
   logic             w_wr_en, w_rd_en;

   assign o_empty     = (r_cnt == '0);
   assign o_full      = (r_cnt == CNT_FULL);
   assign w_rd_en     = i_pop & ~o_empty;
   assign w_wr_en     = i_push & (~o_full | w_rd_en);
   assign o_dout      = r_mem[r_rd];
   assign o_free_next = (w_cnt_nxt != CNT_FULL);

   // Occupancy after this edge.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_wr_en && !w_rd_en)      w_cnt_nxt = r_cnt + (AW+1)'(1);
      else if (!w_wr_en && w_rd_en) w_cnt_nxt = r_cnt - (AW+1)'(1);
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr_en) r_wr <= r_wr + AW'(1);
         if (w_rd_en) r_rd <= r_rd + AW'(1);
         r_cnt <= w_cnt_nxt;
      end
   end

   // Storage carries no reset; validity is tracked by the counter.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr] <= i_din;
   end

endmodule

// File: rtl/fejkon_pcie_cpl_tx.sv
// Completion encoder: buffers memory-access responses and emits one
// single-beat Cpl/CplD TLP per permitted cycle on the hard-IP TX port,
// honouring the hard IP's ready latency.
// Optional: define FEJKON_PCIE_CPL_TX_STATS_EN for stat_* counters.
module fejkon_pcie_cpl_tx #(
   parameter int FIFO_DEPTH    = 4,
   parameter int READY_LATENCY = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [15:0]  cpl_completer_id,
   input  logic [127:0] mem_access_resp_data,
   input  logic         mem_access_resp_valid,
   output logic         mem_access_resp_ready,
   output logic [255:0] tx_st_data,
   output logic         tx_st_startofpacket,
   output logic         tx_st_endofpacket,
   output logic [1:0]   tx_st_empty,
   output logic         tx_st_error,
   output logic         tx_st_valid,
   input  logic         tx_st_ready
`ifdef FEJKON_PCIE_CPL_TX_STATS_EN
   ,
   output logic [31:0]  stat_cpld_cnt,
   output logic [31:0]  stat_cpl_cnt,
   output logic [31:0]  stat_stall_cnt
`endif
);

   import fejkon_pcie_pkg::*;

   logic             w_push, w_pop, w_full, w_empty, w_free_next, w_rdy_dly;
   logic [127:0]     w_head;
   mem_access_resp_t w_head_s;
   logic [255:0]     w_tlp;
   logic             r_resp_ready, r_valid;
   logic [255:0]     r_data;

   assign w_push   = mem_access_resp_valid & r_resp_ready & ~w_full;
   assign w_pop    = w_rdy_dly & ~w_empty;
   assign w_head_s = mem_access_resp_t'(w_head);
   assign w_tlp    = encode_cpl(w_head_s, cpl_completer_id);

   fejkon_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (128)
   ) u_fifo (
      .clk         (clk),
      .rst         (reset),
      .i_push      (w_push),
      .i_din       (mem_access_resp_data),
      .i_pop       (w_pop),
      .o_dout      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_free_next (w_free_next)
   );

   // Permission line: tx_st_ready delayed READY_LATENCY-1 registers, so a
   // beat registered at the edge ending cycle t+RL-1 is seen in cycle t+RL.
   generate
      if (READY_LATENCY == 1) begin : g_rdy_direct
         assign w_rdy_dly = tx_st_ready;
      end else begin : g_rdy_pipe
         logic [READY_LATENCY-2:0] r_rdy_pipe;
         // Shift tx_st_ready through the delay line.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_rdy_pipe <= '0;
            end else begin
               r_rdy_pipe[0] <= tx_st_ready;
               for (int i = 1; i < READY_LATENCY-1; i++)
                  r_rdy_pipe[i] <= r_rdy_pipe[i-1];
            end
         end
         assign w_rdy_dly = r_rdy_pipe[READY_LATENCY-2];
      end
   endgenerate

   // Registered input ready and output beat; idle beats drive zero data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_resp_ready <= 1'b0;
         r_valid      <= 1'b0;
         r_data       <= '0;
      end else begin
         r_resp_ready <= w_free_next;
         r_valid      <= w_pop;
         r_data       <= w_pop ? w_tlp : '0;
      end
   end

   assign mem_access_resp_ready = r_resp_ready;
   assign tx_st_valid           = r_valid;
   assign tx_st_data            = r_data;
   assign tx_st_startofpacket   = r_valid;
   assign tx_st_endofpacket     = r_valid;
   assign tx_st_empty           = r_valid ? 2'd2 : 2'd0;
   assign tx_st_error           = 1'b0;

`ifdef FEJKON_PCIE_CPL_TX_STATS_EN
   logic        w_is_sc;
   logic [31:0] r_cpld_cnt, r_cpl_cnt, r_stall_cnt;

   assign w_is_sc = (norm_status(w_head_s.status) == CPL_SC);

   // Saturating event counters: emitted CplD, emitted Cpl, stalled cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cpld_cnt  <= '0;
         r_cpl_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_pop && w_is_sc && r_cpld_cnt != '1)
            r_cpld_cnt <= r_cpld_cnt + 32'd1;
         if (w_pop && !w_is_sc && r_cpl_cnt != '1)
            r_cpl_cnt <= r_cpl_cnt + 32'd1;
         if (!w_empty && !w_rdy_dly && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stat_cpld_cnt  = r_cpld_cnt;
   assign stat_cpl_cnt   = r_cpl_cnt;
   assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fejkon_pcie_cpl_tx.sv
// Bench for fejkon_pcie_cpl_tx: table of responses with hand-computed
// TLP dwords, a driver feeding a scoreboard on accept and a monitor
// comparing every output cycle, plus backpressure/toggle/reset sequences.
`timescale 1ns/1ps
module tb_fejkon_pcie_cpl_tx;

   localparam int DEPTH = 4;
   localparam int RL    = 3;

   typedef struct {
      logic [2:0]   status;
      logic [15:0]  req;
      logic [7:0]   tag;
      logic [6:0]   la;
      logic [11:0]  bc;
      logic [31:0]  data;
      logic [127:0] exp;   // {dw3, dw2, dw1, dw0}
   } vec_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [15:0]  cpl_id = 16'h0300;
   logic [127:0] resp_data = '0;
   logic         resp_valid = 1'b0;
   logic         resp_ready;
   logic [255:0] tx_data;
   logic         tx_sop, tx_eop, tx_err, tx_valid;
   logic [1:0]   tx_empty;
   logic         tx_rdy = 1'b0;
`ifdef FEJKON_PCIE_CPL_TX_STATS_EN
   logic [31:0]  st_cpld, st_cpl, st_stall;
`endif

   fejkon_pcie_cpl_tx #(.FIFO_DEPTH(DEPTH), .READY_LATENCY(RL)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .cpl_completer_id      (cpl_id),
      .mem_access_resp_data  (resp_data),
      .mem_access_resp_valid (resp_valid),
      .mem_access_resp_ready (resp_ready),
      .tx_st_data            (tx_data),
      .tx_st_startofpacket   (tx_sop),
      .tx_st_endofpacket     (tx_eop),
      .tx_st_empty           (tx_empty),
      .tx_st_error           (tx_err),
      .tx_st_valid           (tx_valid),
      .tx_st_ready           (tx_rdy)
`ifdef FEJKON_PCIE_CPL_TX_STATS_EN
      ,
      .stat_cpld_cnt         (st_cpld),
      .stat_cpl_cnt          (st_cpl),
      .stat_stall_cnt        (st_stall)
`endif
   );

   vec_t         vt [6];
   int           drv_q [$];
   logic [255:0] sb_q [$];
   int           out_cyc_q [$];
   int           hi_q [$];
   int           total = 0, bad = 0, n_acc = 0, cyc = 0, last_acc_cyc = 0;
   int           a0, o0, rise, n;
   logic         drv_acc;
   logic [7:0]   rdy_hist = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] mk(input int i);
      logic [49:0] rs;
      rs = 50'({$urandom(), $urandom()});
      return {vt[i].data, vt[i].req, vt[i].tag, vt[i].status, vt[i].la, vt[i].bc, rs};
   endfunction

   task automatic wait_drain(input string nm, input int max);
      int k = 0;
      while ((drv_q.size() != 0 || sb_q.size() != 0) && k < max) begin
         @(negedge clk); #1;
         k++;
      end
      chk(nm, 256'(drv_q.size() + sb_q.size()), 256'(0));
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Driver: offer the head of drv_q; on accept push its expected beat.
   always begin
      @(negedge clk);
      drv_acc = resp_valid & resp_ready;
      @(posedge clk);
      #1;
      if (drv_acc && !reset && drv_q.size() > 0) begin
         sb_q.push_back({128'h0, vt[drv_q[0]].exp});
         void'(drv_q.pop_front());
         n_acc++;
         last_acc_cyc = cyc;
      end
      if (drv_q.size() > 0) begin
         resp_valid = 1'b1;
         resp_data  = mk(drv_q[0]);
      end else begin
         resp_valid = 1'b0;
         resp_data  = '0;
      end
   end

   // Monitor: every cycle out of reset, check beat against the scoreboard
   // and that tx_st_ready was high READY_LATENCY cycles earlier.
   always @(negedge clk) begin
      rdy_hist = {rdy_hist[6:0], tx_rdy};
      if (!reset) begin
         if (tx_valid) begin
            out_cyc_q.push_back(cyc);
            chk("permission", 256'(rdy_hist[RL]), 256'(1));
            chk("framing", 256'({tx_sop, tx_eop, tx_empty, tx_err}), 256'(5'b11100));
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_tlp: got %h want none", tx_data);
            end else begin
               chk("tlp_data", tx_data, sb_q.pop_front());
            end
         end else begin
            chk("idle_data", tx_data, 256'(0));
            chk("idle_ctl", 256'({tx_sop, tx_eop, tx_empty, tx_err}), 256'(0));
         end
      end
   end

   initial begin
      vt[0] = '{3'b000, 16'h0100, 8'h2A, 7'h10, 12'h004, 32'hDEADBEEF,
                128'hDEADBEEF_01002A10_03000004_4A000001};
      vt[1] = '{3'b001, 16'h0100, 8'h2A, 7'h10, 12'h004, 32'hDEADBEEF,
                128'h00000000_01002A10_03002004_0A000000};
      vt[2] = '{3'b100, 16'hBEEF, 8'hFF, 7'h7F, 12'hFFF, 32'h12345678,
                128'h00000000_BEEFFF7F_03008FFF_0A000000};
      vt[3] = '{3'b010, 16'h0001, 8'h00, 7'h00, 12'h000, 32'hFFFFFFFF,
                128'h00000000_00010000_03008000_0A000000};
      vt[4] = '{3'b000, 16'hFFFF, 8'h80, 7'h7F, 12'h800, 32'hA5A5A5A5,
                128'hA5A5A5A5_FFFF807F_03000800_4A000001};
      vt[5] = '{3'b111, 16'h1234, 8'h56, 7'h01, 12'h004, 32'hCAFEF00D,
                128'h00000000_12345601_03008004_0A000000};

      // Reset state
      step(3);
      chk("rst_data", tx_data, 256'(0));
      chk("rst_ctl", 256'({tx_valid, tx_sop, tx_eop, tx_empty, tx_err, resp_ready}), 256'(0));
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rdy_hold", 256'(resp_ready), 256'(0));
      step(1);
      chk("rdy_after_rst", 256'(resp_ready), 256'(1));

      // Table: one response at a time with continuous permission
      tx_rdy = 1'b1;
      step(RL + 1);
      for (int i = 0; i < 6; i++) begin
         out_cyc_q.delete();
         drv_q.push_back(i);
         wait_drain("drain_vec", 50);
         chk("vec_count", 256'(out_cyc_q.size()), 256'(1));
         if (i == 0) chk("latency", 256'(out_cyc_q[0] - last_acc_cyc), 256'(1));
      end

      // Backpressure: 6 offered with no permission, only DEPTH accepted
      tx_rdy = 1'b0;
      step(RL + 2);
      a0 = n_acc;
      out_cyc_q.delete();
      for (int i = 0; i < 6; i++) drv_q.push_back(i);
      step(20);
      chk("full_acc", 256'(n_acc - a0), 256'(DEPTH));
      chk("full_rdy", 256'(resp_ready), 256'(0));
      chk("full_novalid", 256'(out_cyc_q.size()), 256'(0));
      step(1);
      tx_rdy = 1'b1;
      rise = cyc;
      wait_drain("drain_burst", 60);
      chk("burst_cnt", 256'(out_cyc_q.size()), 256'(6));
      // ready-high cycle counted as cycle 1
      chk("first_valid", 256'(out_cyc_q[0] - rise + 1), 256'(RL + 1));
      chk("burst_span", 256'(out_cyc_q[5] - out_cyc_q[0]), 256'(5));

      // Toggling ready with 4 queued
      step(1);
      tx_rdy = 1'b0;
      step(RL + 2);
      a0 = n_acc;
      for (int i = 2; i < 6; i++) drv_q.push_back(i);
      step(8);
      chk("fill4", 256'(n_acc - a0), 256'(4));
      out_cyc_q.delete();
      hi_q.delete();
      for (int k = 0; k < 8; k++) begin
         step(1);
         tx_rdy = (k % 2 == 0);
         if (tx_rdy) hi_q.push_back(cyc);
      end
      step(1);
      tx_rdy = 1'b0;
      step(RL + 3);
      chk("toggle_cnt", 256'(out_cyc_q.size()), 256'(4));
      for (int i = 0; i < 4; i++)
         chk("toggle_slot", 256'(out_cyc_q[i]), 256'(hi_q[i] + RL));
      chk("toggle_sb", 256'(sb_q.size()), 256'(0));

      // Reset mid-burst with 3 queued
      a0 = n_acc;
      drv_q.push_back(0);
      drv_q.push_back(1);
      drv_q.push_back(4);
      step(6);
      chk("q3", 256'(n_acc - a0), 256'(3));
      out_cyc_q.delete();
      step(1);
      tx_rdy = 1'b1;
      n = 0;
      while (out_cyc_q.size() == 0 && n < 20) begin
         @(negedge clk); #2;
         n++;
      end
      chk("mid_burst", 256'(out_cyc_q.size()), 256'(1));
      reset = 1'b1;
      #1;
      chk("rst_async_valid", 256'(tx_valid), 256'(0));
      chk("rst_async_data", tx_data, 256'(0));
      sb_q.delete();
      drv_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst2_rdy0", 256'(resp_ready), 256'(0));
      o0 = out_cyc_q.size();
      step(1);
      chk("rst2_rdy1", 256'(resp_ready), 256'(1));
      step(12);
      chk("no_replay", 256'(out_cyc_q.size() - o0), 256'(0));

`ifdef FEJKON_PCIE_CPL_TX_STATS_EN
      chk("stat_rst", 256'({st_cpld, st_cpl, st_stall}), 256'(0));
      tx_rdy = 1'b0;
      step(RL + 2);
      a0 = n_acc;
      drv_q.push_back(0);
      n = 0;
      while (n_acc == a0 && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      chk("stat_acc", 256'(n_acc - a0), 256'(1));
      // stalls = extra wait + RL-1 edges until permission arrives
      repeat (5 - (RL - 1)) @(posedge clk);
      #2;
      tx_rdy = 1'b1;
      step(RL + 1);
      drv_q.push_back(4);
      drv_q.push_back(2);
      drv_q.push_back(0);
      drv_q.push_back(5);
      wait_drain("stat_drain", 60);
      step(2);
      chk("stat_cpld", 256'(st_cpld), 256'(3));
      chk("stat_cpl", 256'(st_cpl), 256'(2));
      chk("stat_stall", 256'(st_stall), 256'(5));
`endif

      chk("final_sb", 256'(sb_q.size() + drv_q.size()), 256'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
